// File: rtl/e_door_ctrl_if.sv
// Door controller signal bundle: requests and animator feedback into the controller,
// registered door commands and status back out to the car/floor logic.
interface e_door_ctrl_if;
  logic       arrive;
  logic       open_btn;
  logic       close_btn;
  logic       obstruct;
  logic [3:0] door_pos;
  logic       dO;
  logic       dC;
  logic       car_lock;
  logic [1:0] door_state;
  logic       fault;
  logic       nudge;

  modport master (
    output arrive, open_btn, close_btn, obstruct, door_pos,
    input  dO, dC, car_lock, door_state, fault, nudge
  );

  modport slave (
    input  arrive, open_btn, close_btn, obstruct, door_pos,
    output dO, dC, car_lock, door_state, fault, nudge
  );
endinterface

// File: rtl/e_door_ctrl.sv
// Elevator door sequencer: open/dwell/close with reopen, car interlock and stall fault.
// Define E_DOOR_NUDGE_EN to force a nudge close after three obstruct-caused reopens.
module e_door_ctrl #(
  parameter int DWELL_CYC = 16,
  parameter int MOVE_TMO  = 12
) (
  input logic          clk,
  input logic          rst_n,
  e_door_ctrl_if.slave bus
);

  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int MW = $clog2(MOVE_TMO + 1);

  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYC - 1);
  localparam logic [MW-1:0] MOVE_LAST  = MW'(MOVE_TMO - 1);
  localparam logic [MW-1:0] MOVE_MAX   = MW'(MOVE_TMO);
  localparam logic [3:0]    POS_OPEN   = 4'b0000;
  localparam logic [3:0]    POS_SHUT   = 4'b1111;

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_OPENING = 3'd1,
    S_DWELL   = 3'd2,
    S_CLOSING = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] dwell_cnt, dwell_nx;
  logic [MW-1:0] move_cnt, move_nx;
  logic          open_req;
  logic          hold_req;
  logic          reopen_req;

  assign open_req = bus.arrive | bus.open_btn;
  assign hold_req = bus.obstruct | open_req;

`ifdef E_DOOR_NUDGE_EN
  logic [1:0] reopen_cnt, reopen_nx;
  logic       nudge_mode;

  // Once nudging, only a new arrival may reopen the closing door.
  assign nudge_mode = (reopen_cnt == 2'd3);
  assign reopen_req = nudge_mode ? bus.arrive : hold_req;
`else
  assign reopen_req = hold_req;
`endif

  function automatic logic [1:0] encode_state(input state_t s);
    case (s)
      S_CLOSED:  return 2'd0;
      S_DWELL:   return 2'd2;
      S_CLOSING: return 2'd3;
      default:   return 2'd1;  // OPENING, and FAULT which holds the door open
    endcase
  endfunction

  // NOTE: every signal assigned here gets its default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    dwell_nx = dwell_cnt;
`ifdef E_DOOR_NUDGE_EN
    reopen_nx = reopen_cnt;
`endif
    case (state)
      S_CLOSED: begin
        if (open_req) begin
          state_nx = S_OPENING;
        end else if (bus.door_pos != POS_SHUT) begin
          state_nx = S_CLOSING;
        end
      end
      S_OPENING: begin
        if (bus.door_pos == POS_OPEN) begin
          state_nx = S_DWELL;
          dwell_nx = DWELL_LOAD;
        end else if (move_cnt == MOVE_LAST) begin
          state_nx = S_FAULT;
        end
      end
      S_DWELL: begin
        if (hold_req) begin
          dwell_nx = DWELL_LOAD;
        end else if (bus.close_btn || dwell_cnt == '0) begin
          state_nx = S_CLOSING;
        end else begin
          dwell_nx = dwell_cnt - DW'(1);
        end
      end
      S_CLOSING: begin
        // A reopen request beats completion seen in the same cycle.
        if (reopen_req) begin
          state_nx = S_OPENING;
`ifdef E_DOOR_NUDGE_EN
          if (bus.obstruct && !nudge_mode) begin
            reopen_nx = reopen_cnt + 2'd1;
          end
`endif
        end else if (bus.door_pos == POS_SHUT) begin
          state_nx = S_CLOSED;
        end else if (move_cnt == MOVE_LAST) begin
          state_nx = S_FAULT;
        end
      end
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_FAULT;
    endcase
`ifdef E_DOOR_NUDGE_EN
    if (state_nx == S_CLOSED) begin
      reopen_nx = 2'd0;
    end
`endif
  end

  // Move timer restarts on every entry into a motion state, including a reopen.
  always_comb begin
    move_nx = '0;
    if ((state_nx == S_OPENING || state_nx == S_CLOSING) && state_nx == state) begin
      move_nx = (move_cnt == MOVE_MAX) ? move_cnt : move_cnt + MW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_CLOSED;
      dwell_cnt      <= '0;
      move_cnt       <= '0;
      bus.dO         <= 1'b0;
      bus.dC         <= 1'b0;
      bus.car_lock   <= 1'b0;
      bus.door_state <= 2'd0;
      bus.fault      <= 1'b0;
    end else begin
      state          <= state_nx;
      dwell_cnt      <= dwell_nx;
      move_cnt       <= move_nx;
      bus.dO         <= (state_nx == S_OPENING) || (state_nx == S_FAULT);
      bus.dC         <= (state_nx == S_CLOSING);
      bus.car_lock   <= (state_nx == S_CLOSED) && (bus.door_pos == POS_SHUT);
      bus.door_state <= encode_state(state_nx);
      bus.fault      <= (state_nx == S_FAULT);
    end
  end

`ifdef E_DOOR_NUDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reopen_cnt <= 2'd0;
      bus.nudge  <= 1'b0;
    end else begin
      reopen_cnt <= reopen_nx;
      bus.nudge  <= (state_nx == S_CLOSING) && (reopen_nx == 2'd3);
    end
  end
`else
  assign bus.nudge = 1'b0;
`endif

endmodule

// File: tb/tb_e_door_ctrl.sv
// Self-checking bench for e_door_ctrl: directed door scenarios plus random requests,
// compared every cycle against a rule-level model of the door sequence.
module tb_e_door_ctrl;

  localparam int         DWELL_CYC = 16;
  localparam int         MOVE_TMO  = 12;
  localparam logic [3:0] POS_OPEN  = 4'b0000;
  localparam logic [3:0] POS_SHUT  = 4'b1111;
`ifdef E_DOOR_NUDGE_EN
  localparam bit NUDGE_ON = 1'b1;
`else
  localparam bit NUDGE_ON = 1'b0;
`endif

  localparam int PH_CLOSED  = 0;
  localparam int PH_OPENING = 1;
  localparam int PH_DWELL   = 2;
  localparam int PH_CLOSING = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  e_door_ctrl_if bus ();

  e_door_ctrl #(
    .DWELL_CYC(DWELL_CYC),
    .MOVE_TMO (MOVE_TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         m_phase;
  int         m_dwell_left;
  int         m_moving;
  int         m_reopens;
  bit         m_fault;
  logic [6:0] exp_out;
  bit         anim_freeze;
  logic [3:0] pos_set [5] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.fault, bus.nudge, bus.car_lock, bus.dO, bus.dC, bus.door_state};
  endfunction

  task automatic model_reset();
    m_phase      = PH_CLOSED;
    m_dwell_left = 0;
    m_moving     = 0;
    m_reopens    = 0;
    m_fault      = 1'b0;
    exp_out      = '0;
  endtask

  task automatic enter(input int ph);
    m_phase  = ph;
    m_moving = 0;
  endtask

  // Door rules evaluated once per clock edge on the inputs the DUT samples.
  task automatic model_step();
    bit req     = bus.arrive | bus.open_btn;
    bit hold    = bus.obstruct | req;
    bit nudging = NUDGE_ON && (m_reopens == 3);
    logic [3:0] pos = bus.door_pos;
    if (!m_fault) begin
      case (m_phase)
        PH_CLOSED: begin
          if (req) enter(PH_OPENING);
          else if (pos != POS_SHUT) enter(PH_CLOSING);
        end
        PH_OPENING: begin
          m_moving++;
          if (pos == POS_OPEN) begin
            m_phase      = PH_DWELL;
            m_dwell_left = DWELL_CYC;
          end else if (m_moving >= MOVE_TMO) begin
            m_fault = 1'b1;
          end
        end
        PH_DWELL: begin
          if (hold) m_dwell_left = DWELL_CYC;
          else if (bus.close_btn) enter(PH_CLOSING);
          else begin
            m_dwell_left--;
            if (m_dwell_left == 0) enter(PH_CLOSING);
          end
        end
        default: begin
          m_moving++;
          if (nudging ? bus.arrive : hold) begin
            if (bus.obstruct && m_reopens < 3) m_reopens++;
            enter(PH_OPENING);
          end else if (pos == POS_SHUT) begin
            m_phase   = PH_CLOSED;
            m_reopens = 0;
          end else if (m_moving >= MOVE_TMO) begin
            m_fault = 1'b1;
          end
        end
      endcase
    end
    if (m_fault) begin
      exp_out = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    end else begin
      exp_out = {1'b0,
                 NUDGE_ON && m_phase == PH_CLOSING && m_reopens == 3,
                 m_phase == PH_CLOSED && pos == POS_SHUT,
                 m_phase == PH_OPENING,
                 m_phase == PH_CLOSING,
                 2'(m_phase)};
    end
  endtask

  // One clock: model the edge, compare 1 ns later, then move the animator one step.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("outputs", 32'(outs()), 32'(exp_out));
    if (!anim_freeze) begin
      if (bus.dO) bus.door_pos = bus.door_pos << 1;
      else if (bus.dC) bus.door_pos = {1'b1, bus.door_pos[3:1]};
    end
  endtask

  task automatic do_reset(input logic [3:0] pos);
    rst_n         = 1'b0;
    bus.arrive    = 1'b0;
    bus.open_btn  = 1'b0;
    bus.close_btn = 1'b0;
    bus.obstruct  = 1'b0;
    bus.door_pos  = pos;
    anim_freeze   = 1'b0;
    #1;
    check("reset_outputs", 32'(outs()), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] ds, input int budget, input string tag);
    int n = 0;
    while (bus.door_state !== ds && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.door_state), 32'(ds));
  endtask

  task automatic dwell_len(output int n);
    n = 0;
    while (bus.door_state == 2'd2 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic pulse_arrive();
    bus.arrive = 1'b1;
    tick();
    bus.arrive = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    bus.arrive    = 1'b0;
    bus.open_btn  = 1'b0;
    bus.close_btn = 1'b0;
    bus.obstruct  = 1'b0;
    bus.door_pos  = POS_SHUT;
    anim_freeze   = 1'b0;
    model_reset();
    #2;

    // Reset, then a normal open/dwell/close cycle.
    do_reset(POS_SHUT);
    tick();
    check("idle_lock", 32'(bus.car_lock), 32'd1);
    pulse_arrive();
    check("arrive_dO", 32'(bus.dO), 32'd1);
    check("arrive_unlock", 32'(bus.car_lock), 32'd0);
    wait_state(2'd2, 20, "reach_dwell");
    check("open_dO_off", 32'(bus.dO), 32'd0);
    dwell_len(n);
    check("dwell_len", 32'(n), 32'(DWELL_CYC));
    check("close_dC", 32'(bus.dC), 32'd1);

    // Obstruct while closing at 1100 reopens, then a full dwell follows.
    n = 0;
    while (bus.door_pos != 4'b1100 && n < 10) begin
      tick();
      n++;
    end
    check("reach_1100", 32'(bus.door_pos), 32'(4'b1100));
    bus.obstruct = 1'b1;
    tick();
    bus.obstruct = 1'b0;
    check("reopen_dC", 32'(bus.dC), 32'd0);
    check("reopen_dO", 32'(bus.dO), 32'd1);
    wait_state(2'd2, 20, "reopen_dwell");
    dwell_len(n);
    check("dwell_after_reopen", 32'(n), 32'(DWELL_CYC));
    wait_state(2'd0, 20, "closed_after_reopen");
    check("closed_lock", 32'(bus.car_lock), 32'd1);

    // Early close: close_btn with open_btn reloads, close_btn alone closes.
    pulse_arrive();
    wait_state(2'd2, 20, "early_dwell");
    repeat (5) tick();
    bus.close_btn = 1'b1;
    bus.open_btn  = 1'b1;
    tick();
    bus.open_btn = 1'b0;
    check("close_open_stays", 32'(bus.door_state), 32'd2);
    tick();
    bus.close_btn = 1'b0;
    check("early_close_dC", 32'(bus.dC), 32'd1);
    wait_state(2'd0, 20, "early_closed");

    // Three obstruct reopens, then obstruct held on the fourth close.
    pulse_arrive();
    for (int r = 0; r < 3; r++) begin
      wait_state(2'd3, 40, "nudge_closing");
      bus.obstruct = 1'b1;
      tick();
      bus.obstruct = 1'b0;
      check("nudge_reopen", 32'(bus.door_state), 32'd1);
    end
    wait_state(2'd3, 40, "fourth_close");
    bus.obstruct = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen |= bus.nudge;
    end
    bus.obstruct = 1'b0;
    check("nudge_seen", 32'(seen), 32'(NUDGE_ON));
    check("held_obstruct_state", 32'(bus.door_state), NUDGE_ON ? 32'd0 : 32'd2);
    wait_state(2'd0, 60, "nudge_done");
    check("nudge_cleared", 32'(bus.nudge), 32'd0);

    // Stall while opening: fault after MOVE_TMO cycles, sticky until reset.
    pulse_arrive();
    bus.door_pos = 4'b1110;
    anim_freeze  = 1'b1;
    n = 0;
    while (!bus.fault && n < 50) begin
      tick();
      n++;
    end
    check("stall_cycles", 32'(n), 32'(MOVE_TMO));
    check("fault_dO", 32'(bus.dO), 32'd1);
    check("fault_lock", 32'(bus.car_lock), 32'd0);
    repeat (3) tick();
    check("fault_sticky", 32'(bus.fault), 32'd1);

    // Reset with a partly open door recovers by closing.
    do_reset(4'b1000);
    tick();
    check("recover_state", 32'(bus.door_state), 32'd3);
    check("recover_dC", 32'(bus.dC), 32'd1);
    check("recover_nolock", 32'(bus.car_lock), 32'd0);
    wait_state(2'd0, 20, "recover_closed");
    check("recover_lock", 32'(bus.car_lock), 32'd1);

    // Random requests with occasional animator stalls.
    for (int i = 0; i < 1500; i++) begin
      bus.arrive    = ($urandom_range(0, 99) < 3);
      bus.open_btn  = ($urandom_range(0, 99) < 4);
      bus.close_btn = ($urandom_range(0, 99) < 6);
      bus.obstruct  = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 199) == 0) anim_freeze = ~anim_freeze;
      tick();
      if (bus.fault) do_reset(pos_set[$urandom_range(0, 4)]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/e_door_ctrl.md
Name: e_door_ctrl

Overview:
Sequencing controller for the elevator door animation datapath. It issues level-held open/close commands (dO/dC) to the door animator and watches the animator's 4-bit panel pattern to know when the door has finished moving. It times the open dwell, reopens the door on an obstruction or call, interlocks car motion and detects a stalled door. It sits between the floor/call logic and the door animator in the Elevator2 top level.

Parameters:
DWELL_CYC, 16, cycles the door stays fully open before auto-close (>=2)
MOVE_TMO, 12, max cycles allowed in OPENING or CLOSING before a fault (>=6)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
arrive  in  1  1-cycle pulse: car has stopped level at a floor
open_btn  in  1  door-open request, level
close_btn  in  1  door-close request, level
obstruct  in  1  door-edge obstruction sensor, level
door_pos  in  4  animator pattern: 4'b0000 = fully open, 4'b1111 = fully closed
dO  out  1  open command to the animator, registered
dC  out  1  close command to the animator, registered
car_lock  out  1  1 = door proven closed, car may move; registered
door_state  out  2  0 CLOSED, 1 OPENING, 2 DWELL, 3 CLOSING
fault  out  1  sticky door-stall fault
nudge  out  1  forced-close indication (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=CLOSED, dO=0, dC=0, car_lock=0, fault=0, nudge=0, dwell and move counters cleared. Reset mid-motion abandons the motion immediately.
- All outputs are registered from the next state. A command appears one cycle after the triggering input is sampled.
- dO and dC are never 1 together.
- CLOSED:
  - arrive|open_btn -> OPENING.
  - If door_pos != 4'b1111 and no request is present -> CLOSING. This recovers a partly open door after reset.
  - car_lock=1 only while in CLOSED and door_pos==4'b1111.
- OPENING:
  - dO=1.
  - door_pos==4'b0000 -> DWELL, dwell counter loaded with DWELL_CYC-1.
- DWELL:
  - dO=dC=0.
  - Counter decrements each cycle.
  - obstruct|open_btn|arrive reloads DWELL_CYC-1. Reload has priority over close_btn.
  - close_btn with none of the above sets the next state to CLOSING immediately.
  - Counter==0 -> CLOSING.
- CLOSING:
  - dC=1.
  - door_pos==4'b1111 -> CLOSED.
  - obstruct|open_btn|arrive -> OPENING (reopen): dC drops and dO rises on the same next edge. Reopen has priority over completion when both occur in the same cycle.
- Move timer:
  - Cleared on entry to OPENING or CLOSING; increments while in either state.
  - Reaching MOVE_TMO -> FAULT.
- FAULT:
  - Encoded as door_state=1 with fault=1. dO=1 (fail open), dC=0, car_lock=0.
  - Exits only via reset.
- Priority at any cycle: fault > obstruct > open_btn/arrive > close_btn > timer expiry.
- Counter widths are sized with $clog2 of the parameter and saturate; no wrap-around.

Optional Feature:
- Macro: E_DOOR_NUDGE_EN.
- When defined:
  - A 2-bit reopen counter increments on each obstruct-caused CLOSING->OPENING.
  - The counter clears on entry to CLOSED.
  - When it reaches 3, the next CLOSING ignores obstruct and open_btn (arrive still honoured) and asserts nudge=1 until CLOSED.
- When undefined:
  - No reopen counter.
  - nudge is tied 0.
  - Obstruct always reopens.

Test Plan:
- Normal cycle, DWELL_CYC=16: reset, door_pos=1111, pulse arrive -> dO=1 next cycle. Model the animator (1 step/cycle); at door_pos=0000 dO=0. After 16 cycles dC=1; at 1111, door_state=0 and car_lock=1.
- Reopen: during CLOSING at door_pos=1100, assert obstruct 1 cycle -> next edge dC=0 and dO=1. After reaching 0000, dwell restarts at a full 16 cycles.
- Early close: in DWELL, close_btn=1 at dwell count 10 -> dC=1 next cycle. close_btn together with open_btn -> dwell reload, no close.
- Stall: in OPENING, hold door_pos=1110 -> after 12 cycles fault=1, dO=1, car_lock=0. State persists until rst_n=0, which forces all outputs to their reset values asynchronously.
- Reset recovery: release reset with door_pos=1000 -> door_state=3, dC=1; car_lock stays 0 until 1111.
- E_DOOR_NUDGE_EN: three obstruct reopens, then obstruct held on the fourth close -> nudge=1 and dC=1 until 1111, then nudge=0. Without the macro the same stimulus reopens a fourth time and nudge stays 0.
